// File: rtl/csc_pkg.sv
// Shared encodings and coefficient sets for the RGB->YCbCr converter.
// Coefficients are signed, scaled by 2^CSC_FRAC.
package csc_pkg;
  typedef enum logic [1:0] {
    CSC_MODE_601 = 2'd0,
    CSC_MODE_709 = 2'd1,
    CSC_MODE_BYP = 2'd2,
    CSC_MODE_RSV = 2'd3
  } csc_mode_e;

  localparam int CSC_FRAC = 8;
  localparam int CSC_RND  = 128;
  localparam int COEF_W   = 10;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef struct packed { coef_t r; coef_t g; coef_t b; } coef3_t;

  localparam coef3_t C601_Y  = '{r:  10'sd77,  g:  10'sd150, b:  10'sd29};
  localparam coef3_t C601_CB = '{r: -10'sd43,  g: -10'sd85,  b:  10'sd128};
  localparam coef3_t C601_CR = '{r:  10'sd128, g: -10'sd107, b: -10'sd21};
  localparam coef3_t C709_Y  = '{r:  10'sd54,  g:  10'sd184, b:  10'sd18};
  localparam coef3_t C709_CB = '{r: -10'sd29,  g: -10'sd99,  b:  10'sd128};
  localparam coef3_t C709_CR = '{r:  10'sd128, g: -10'sd116, b: -10'sd12};
  // Bypass is a unit-gain selection so it shares the datapath exactly.
  localparam coef3_t CBYP_Y  = '{r:  10'sd0,   g:  10'sd256, b:  10'sd0};
  localparam coef3_t CBYP_CB = '{r:  10'sd0,   g:  10'sd0,   b:  10'sd256};
  localparam coef3_t CBYP_CR = '{r:  10'sd256, g:  10'sd0,   b:  10'sd0};
endpackage

// File: rtl/csc_dot3.sv
// One output channel: 3 signed products -> sum + offset -> shift and clamp.
// i_offset is consumed in the second stage, so it must align with stage-1 data.
module csc_dot3 import csc_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [2:0][DATA_W-1:0]   i_px,
  input  coef3_t                   i_coef,
  input  logic signed [DATA_W+10:0] i_offset,
  output logic [DATA_W-1:0]        o_res
);
  localparam int PW = DATA_W + 9;
  localparam int AW = DATA_W + 11;
  localparam logic signed [AW-1:0] MAXV = AW'((1 << DATA_W) - 1);

  coef_t                 w_c [3];
  logic signed [PW-1:0]  r_prod [3];
  logic signed [AW-1:0]  r_acc;
  logic signed [AW-1:0]  w_sh;
  logic [DATA_W-1:0]     r_res;

  assign w_c[0] = i_coef.r;
  assign w_c[1] = i_coef.g;
  assign w_c[2] = i_coef.b;
  assign w_sh   = r_acc >>> CSC_FRAC;
  assign o_res  = r_res;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int k = 0; k < 3; k++) r_prod[k] <= '0;
      r_acc <= '0;
      r_res <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        r_prod[k] <= PW'($signed({1'b0, i_px[k]})) * PW'(w_c[k]);
      r_acc <= AW'(r_prod[0]) + AW'(r_prod[1]) + AW'(r_prod[2]) + i_offset;
      if (w_sh < 0)         r_res <= '0;
      else if (w_sh > MAXV) r_res <= '1;
      else                  r_res <= w_sh[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/csc_rgb2ycbcr.sv
// Frame-synchronous RGB->YCbCr converter, fixed 3-cycle latency.
// Define CSC_BT709_EN to build the BT.709 matrix; otherwise mode 1 falls back to BT.601.
module csc_rgb2ycbcr import csc_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              per_img_vsync,
  input  logic              per_img_href,
  input  logic [DATA_W-1:0] per_img_red,
  input  logic [DATA_W-1:0] per_img_green,
  input  logic [DATA_W-1:0] per_img_blue,
  input  logic [1:0]        csc_mode,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr,
  output logic [1:0]        csc_mode_active
);
  localparam int STAGES = 3;
  localparam int AW     = DATA_W + 11;
  localparam logic signed [AW-1:0] OFF_L = AW'(CSC_RND);
  localparam logic signed [AW-1:0] OFF_C = AW'(CSC_RND + (1 << (DATA_W - 1 + CSC_FRAC)));

  function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
    case (m)
      CSC_MODE_BYP: return CSC_MODE_BYP;
`ifdef CSC_BT709_EN
      CSC_MODE_709: return CSC_MODE_709;
`endif
      default:      return CSC_MODE_601;
    endcase
  endfunction

  logic                     r_vs_d;
  logic [1:0]               r_mode, r_tag, w_mode;
  logic                     w_vs_rise;
  logic [STAGES-1:0]        r_href_sr, r_vs_sr;
  logic [2:0][DATA_W-1:0]   w_px;
  coef3_t                   w_coef [3];
  logic signed [AW-1:0]     w_off  [3];
  logic [DATA_W-1:0]        w_res  [3];

  // A pixel arriving with the frame-start edge already uses the new mode.
  assign w_vs_rise = per_img_vsync & ~r_vs_d;
  assign w_mode    = w_vs_rise ? mode_sanitize(csc_mode) : r_mode;
  assign w_px      = {per_img_blue, per_img_green, per_img_red};

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_vs_d    <= 1'b0;
      r_mode    <= CSC_MODE_601;
      r_tag     <= CSC_MODE_601;
      r_href_sr <= '0;
      r_vs_sr   <= '0;
    end else begin
      r_vs_d    <= per_img_vsync;
      if (w_vs_rise) r_mode <= mode_sanitize(csc_mode);
      r_tag     <= w_mode;
      r_href_sr <= {r_href_sr[STAGES-2:0], per_img_href};
      r_vs_sr   <= {r_vs_sr[STAGES-2:0], per_img_vsync};
    end
  end

  always_comb begin
    w_coef[0] = C601_Y;
    w_coef[1] = C601_CB;
    w_coef[2] = C601_CR;
    case (w_mode)
      CSC_MODE_BYP: begin
        w_coef[0] = CBYP_Y;
        w_coef[1] = CBYP_CB;
        w_coef[2] = CBYP_CR;
      end
`ifdef CSC_BT709_EN
      CSC_MODE_709: begin
        w_coef[0] = C709_Y;
        w_coef[1] = C709_CB;
        w_coef[2] = C709_CR;
      end
`endif
      default: ;
    endcase
  end

  // Chroma offset follows the stage-1 tag so in-flight pixels keep their mode.
  assign w_off[0] = OFF_L;
  assign w_off[1] = (r_tag == CSC_MODE_BYP) ? OFF_L : OFF_C;
  assign w_off[2] = (r_tag == CSC_MODE_BYP) ? OFF_L : OFF_C;

  for (genvar k = 0; k < 3; k++) begin : g_ch
    csc_dot3 #(.DATA_W(DATA_W)) u_dot3 (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .i_px     (w_px),
      .i_coef   (w_coef[k]),
      .i_offset (w_off[k]),
      .o_res    (w_res[k])
    );
  end

  assign post_img_href   = r_href_sr[STAGES-1];
  assign post_img_vsync  = r_vs_sr[STAGES-1];
  assign post_img_Y      = post_img_href ? w_res[0] : '0;
  assign post_img_Cb     = post_img_href ? w_res[1] : '0;
  assign post_img_Cr     = post_img_href ? w_res[2] : '0;
  assign csc_mode_active = r_mode;
endmodule

// File: tb/tb_csc_rgb2ycbcr.sv
// Directed bench for csc_rgb2ycbcr (DATA_W=8) with hand-computed pixels.
module tb_csc_rgb2ycbcr;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       per_img_vsync, per_img_href;
  logic [7:0] per_img_red, per_img_green, per_img_blue;
  logic [1:0] csc_mode;
  logic       post_img_vsync, post_img_href;
  logic [7:0] post_img_Y, post_img_Cb, post_img_Cr;
  logic [1:0] csc_mode_active;

  int n_chk = 0;
  int n_err = 0;

`ifdef CSC_BT709_EN
  localparam int ACT1 = 1;
  localparam int BL_Y = 18, BL_CB = 255, BL_CR = 116;
`else
  localparam int ACT1 = 0;
  localparam int BL_Y = 29, BL_CB = 255, BL_CR = 107;
`endif

  csc_rgb2ycbcr #(.DATA_W(8)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .per_img_vsync   (per_img_vsync),
    .per_img_href    (per_img_href),
    .per_img_red     (per_img_red),
    .per_img_green   (per_img_green),
    .per_img_blue    (per_img_blue),
    .csc_mode        (csc_mode),
    .post_img_vsync  (post_img_vsync),
    .post_img_href   (post_img_href),
    .post_img_Y      (post_img_Y),
    .post_img_Cb     (post_img_Cb),
    .post_img_Cr     (post_img_Cr),
    .csc_mode_active (csc_mode_active)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic vs, input logic hr, input int r, input int g, input int b);
    per_img_vsync = vs;
    per_img_href  = hr;
    per_img_red   = 8'(r);
    per_img_green = 8'(g);
    per_img_blue  = 8'(b);
  endtask

  // One isolated pixel: checks exact 3-cycle latency and output gating.
  task automatic px(input string tag, input logic vs, input int r, input int g, input int b,
                    input int ey, input int ecb, input int ecr);
    drive(vs, 1'b1, r, g, b);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    step();
    chk({tag, "_href_early"}, post_img_href, 0);
    step();
    chk({tag, "_href"}, post_img_href, 1);
    chk({tag, "_vsync"}, post_img_vsync, vs);
    chk({tag, "_Y"}, post_img_Y, ey);
    chk({tag, "_Cb"}, post_img_Cb, ecb);
    chk({tag, "_Cr"}, post_img_Cr, ecr);
    step();
    chk({tag, "_href_end"}, post_img_href, 0);
    chk({tag, "_Y_gated"}, post_img_Y, 0);
  endtask

  task automatic vpulse(input logic [1:0] m);
    csc_mode      = m;
    per_img_vsync = 1'b1;
    step();
    per_img_vsync = 1'b0;
    step();
  endtask

  initial begin
    sys_rst = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    csc_mode = 2'd0;
    #3;
    chk("rst_href", post_img_href, 0);
    chk("rst_vsync", post_img_vsync, 0);
    chk("rst_Cb", post_img_Cb, 0);
    chk("rst_mode", csc_mode_active, 0);
    step();
    step();
    sys_rst = 1'b1;
    step();

    vpulse(2'd0);
    chk("mode601", csc_mode_active, 0);
    px("white", 1'b0, 255, 255, 255, 255, 128, 128);
    px("black", 1'b0, 0, 0, 0, 0, 128, 128);
    px("red",   1'b0, 255, 0, 0, 77, 85, 255);
    px("green", 1'b0, 0, 255, 0, 149, 43, 21);
    px("mix",   1'b0, 100, 50, 200, 82, 195, 141);

    vpulse(2'd1);
    chk("mode709_req", csc_mode_active, ACT1);
    px("blue", 1'b0, 0, 0, 255, BL_Y, BL_CB, BL_CR);
    vpulse(2'd3);
    chk("mode_rsv", csc_mode_active, 0);

    // Mode request mid-frame is ignored.
    csc_mode = 2'd2;
    step();
    px("midframe", 1'b0, 100, 50, 200, 82, 195, 141);
    chk("midframe_mode", csc_mode_active, 0);

    // Old-mode pixel in flight, then frame-start pixel in the new mode.
    drive(1'b0, 1'b1, 255, 0, 0);
    step();
    drive(1'b1, 1'b1, 10, 20, 30);
    step();
    chk("switch_mode", csc_mode_active, 2);
    drive(1'b0, 1'b0, 0, 0, 0);
    step();
    chk("flight_Y", post_img_Y, 77);
    chk("flight_Cb", post_img_Cb, 85);
    chk("flight_Cr", post_img_Cr, 255);
    chk("flight_vsync", post_img_vsync, 0);
    step();
    chk("newfr_Y", post_img_Y, 20);
    chk("newfr_Cb", post_img_Cb, 30);
    chk("newfr_Cr", post_img_Cr, 10);
    chk("newfr_vsync", post_img_vsync, 1);
    step();
    step();
    px("bypass", 1'b0, 10, 20, 30, 20, 30, 10);

    // Back-to-back frame starts without pixels: the last one wins.
    vpulse(2'd0);
    vpulse(2'd2);
    chk("lastvs_a", csc_mode_active, 2);
    vpulse(2'd2);
    vpulse(2'd0);
    chk("lastvs_b", csc_mode_active, 0);
    step();
    step();

    // Reset with a pixel in flight.
    drive(1'b0, 1'b1, 255, 255, 255);
    step();
    step();
    sys_rst = 1'b0;
    #1;
    chk("midrst_href", post_img_href, 0);
    chk("midrst_Y", post_img_Y, 0);
    chk("midrst_Cb", post_img_Cb, 0);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    sys_rst = 1'b1;
    step();
    step();
    chk("flushed_href", post_img_href, 0);
    chk("postrst_mode", csc_mode_active, 0);
    px("postrst", 1'b0, 0, 0, 0, 0, 128, 128);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
